// File: rtl/eth_mac_tx_framer.sv
// ---------------------------------------------------------------------------
// eth_mac_tx_framer
//
// Transmit-side frame encapsulator for the tri-mode MAC. It takes user frames
// (DA..payload, no FCS) on an AXIS slave and emits the following on an AXIS
// master toward the RGMII transmitter:
//   - 7 x 0x55 preamble and a 0xD5 SFD,
//   - the user data,
//   - zero padding up to C_MIN_LEN bytes,
//   - the 4-byte CRC-32 FCS, least significant byte first,
//   - then the inter-frame gap, counted in consumed byte slots.
// Line rate is set downstream: the RGMII side pulses tready once per byte time.
//
// Optional feature: define TX_FRAME_STATS_EN to add the tx_frame_cnt and
// tx_underrun_cnt statistics outputs.
//
// Ports:
//   tx_mac_aclk          in   clock
//   tx_mac_reset         in   synchronous, active-high reset
//   tx_axis_mac_tdata    in   [7:0] user frame byte
//   tx_axis_mac_tvalid   in   user byte valid
//   tx_axis_mac_tlast    in   last user byte of frame
//   tx_axis_mac_tready   out  block accepts user byte (combinational)
//   tx_axis_rgmii_tdata  out  [7:0] encapsulated byte (registered)
//   tx_axis_rgmii_tvalid out  byte valid (registered); low marks end of frame
//   tx_axis_rgmii_tready in   RGMII TX consumes the byte
//   tx_underrun          out  one-cycle pulse when the user stream starves
//   tx_frame_cnt         out  [31:0] completed frames      (TX_FRAME_STATS_EN)
//   tx_underrun_cnt      out  [15:0] underrun events       (TX_FRAME_STATS_EN)
// ---------------------------------------------------------------------------
`default_nettype none

module eth_mac_tx_framer #(
    parameter int C_IFG     = 96,
    parameter int C_MIN_LEN = 60
) (
    input  logic       tx_mac_aclk,
    input  logic       tx_mac_reset,
    input  logic [7:0] tx_axis_mac_tdata,
    input  logic       tx_axis_mac_tvalid,
    input  logic       tx_axis_mac_tlast,
    output logic       tx_axis_mac_tready,
    output logic [7:0] tx_axis_rgmii_tdata,
    output logic       tx_axis_rgmii_tvalid,
    input  logic       tx_axis_rgmii_tready,
    output logic       tx_underrun
`ifdef TX_FRAME_STATS_EN
    ,
    output logic [31:0] tx_frame_cnt,
    output logic [15:0] tx_underrun_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [7:0]  IFG_SLOTS = 8'(C_IFG / 8);
    localparam logic [11:0] MIN_LEN   = 12'(C_MIN_LEN);

    // Reflected CRC-32 (poly 0xEDB88320), one byte per call.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state;
    logic [2:0]  pre_cnt;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic [1:0]  fcs_idx;
    logic [7:0]  ifg_cnt;
    logic        drain;

    logic        adv;
    logic        slot;
    logic        ifg_done;
    logic        drain_after;
    logic [10:0] cnt_next;
    logic [11:0] cnt_plus1;
    logic [7:0]  fcs_byte;
    logic [31:0] crc_inv;

    // The output register may load whenever it is empty or being consumed.
    assign adv  = !tx_axis_rgmii_tvalid || tx_axis_rgmii_tready;
    // A gap slot is a byte time in which the line sees no valid data.
    assign slot = tx_axis_rgmii_tready && !tx_axis_rgmii_tvalid;

    // During the post-underrun drain the rest of the user frame is swallowed.
    assign tx_axis_mac_tready = adv && ((state == S_DATA) || ((state == S_IFG) && drain));

    // Derived counts, gap completion and FCS byte selection.
    always_comb begin
        cnt_next    = (byte_cnt == 11'h7FF) ? byte_cnt : (byte_cnt + 11'd1);
        cnt_plus1   = {1'b0, byte_cnt} + 12'd1;
        ifg_done    = (ifg_cnt >= IFG_SLOTS) || (slot && ((ifg_cnt + 8'd1) >= IFG_SLOTS));
        drain_after = drain && !(tx_axis_mac_tvalid && tx_axis_mac_tlast);
        crc_inv     = ~crc;
        case (fcs_idx)
            2'd0:    fcs_byte = crc_inv[7:0];
            2'd1:    fcs_byte = crc_inv[15:8];
            2'd2:    fcs_byte = crc_inv[23:16];
            2'd3:    fcs_byte = crc_inv[31:24];
            default: fcs_byte = 8'h00;
        endcase
    end

    // Framing FSM with registered output byte, CRC, counters and statistics.
    always_ff @(posedge tx_mac_aclk) begin
        if (tx_mac_reset) begin
            state                <= S_IDLE;
            tx_axis_rgmii_tdata  <= 8'h00;
            tx_axis_rgmii_tvalid <= 1'b0;
            tx_underrun          <= 1'b0;
            pre_cnt              <= 3'd0;
            byte_cnt             <= 11'd0;
            crc                  <= 32'hFFFFFFFF;
            fcs_idx              <= 2'd0;
            ifg_cnt              <= 8'd0;
            drain                <= 1'b0;
`ifdef TX_FRAME_STATS_EN
            tx_frame_cnt         <= 32'd0;
            tx_underrun_cnt      <= 16'd0;
`endif
        end else begin
            tx_underrun <= 1'b0;
            if (adv) begin
                case (state)
                    S_IDLE: begin
                        tx_axis_rgmii_tvalid <= 1'b0;
                        if (tx_axis_mac_tvalid) begin
                            state   <= S_PRE;
                            pre_cnt <= 3'd0;
                        end
                    end
                    S_PRE: begin
                        tx_axis_rgmii_tdata  <= 8'h55;
                        tx_axis_rgmii_tvalid <= 1'b1;
                        pre_cnt              <= pre_cnt + 3'd1;
                        if (pre_cnt == 3'd6) begin
                            state <= S_SFD;
                        end
                    end
                    S_SFD: begin
                        tx_axis_rgmii_tdata  <= 8'hD5;
                        tx_axis_rgmii_tvalid <= 1'b1;
                        crc                  <= 32'hFFFFFFFF;
                        byte_cnt             <= 11'd0;
                        state                <= S_DATA;
                    end
                    S_DATA: begin
                        if (tx_axis_mac_tvalid) begin
                            tx_axis_rgmii_tdata  <= tx_axis_mac_tdata;
                            tx_axis_rgmii_tvalid <= 1'b1;
                            crc                  <= crc32_byte(crc, tx_axis_mac_tdata);
                            byte_cnt             <= cnt_next;
                            fcs_idx              <= 2'd0;
                            if (tx_axis_mac_tlast) begin
                                state <= (cnt_plus1 < MIN_LEN) ? S_PAD : S_FCS;
                            end
                        end else begin
                            // Starved mid-frame: cut the frame, no FCS.
                            tx_axis_rgmii_tvalid <= 1'b0;
                            tx_underrun          <= 1'b1;
                            drain                <= 1'b1;
                            ifg_cnt              <= 8'd0;
                            state                <= S_IFG;
`ifdef TX_FRAME_STATS_EN
                            tx_underrun_cnt      <= tx_underrun_cnt + 16'd1;
`endif
                        end
                    end
                    S_PAD: begin
                        tx_axis_rgmii_tdata  <= 8'h00;
                        tx_axis_rgmii_tvalid <= 1'b1;
                        crc                  <= crc32_byte(crc, 8'h00);
                        byte_cnt             <= cnt_next;
                        fcs_idx              <= 2'd0;
                        if (cnt_plus1 >= MIN_LEN) begin
                            state <= S_FCS;
                        end
                    end
                    S_FCS: begin
                        tx_axis_rgmii_tdata  <= fcs_byte;
                        tx_axis_rgmii_tvalid <= 1'b1;
                        fcs_idx              <= fcs_idx + 2'd1;
                        if (fcs_idx == 2'd3) begin
                            ifg_cnt <= 8'd0;
                            state   <= S_IFG;
`ifdef TX_FRAME_STATS_EN
                            tx_frame_cnt <= tx_frame_cnt + 32'd1;
`endif
                        end
                    end
                    S_IFG: begin
                        tx_axis_rgmii_tvalid <= 1'b0;
                        drain                <= drain_after;
                        if (slot && (ifg_cnt < IFG_SLOTS)) begin
                            ifg_cnt <= ifg_cnt + 8'd1;
                        end
                        if (ifg_done && !drain_after) begin
                            // A waiting frame starts its preamble right after
                            // the last gap slot so the gap is exactly C_IFG.
                            if (tx_axis_mac_tvalid && !drain) begin
                                tx_axis_rgmii_tdata  <= 8'h55;
                                tx_axis_rgmii_tvalid <= 1'b1;
                                pre_cnt              <= 3'd1;
                                state                <= S_PRE;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        tx_axis_rgmii_tvalid <= 1'b0;
                        state                <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eth_mac_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_eth_mac_tx_framer
//
// Directed, self-checking bench for eth_mac_tx_framer. A table of frame
// vectors (length, RGMII tready cadence, expected totals) is run in a loop,
// followed by hand-written sequences for back-to-back gap, underrun/drain
// and reset during padding. Expected streams come from a local frame model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_eth_mac_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tready;
    logic [7:0] r_tdata;
    logic       r_tvalid;
    logic       r_tready;
    logic       underrun;
`ifdef TX_FRAME_STATS_EN
    logic [31:0] frame_cnt;
    logic [15:0] underrun_cnt;
`endif

    eth_mac_tx_framer dut (
        .tx_mac_aclk         (clk),
        .tx_mac_reset        (rst),
        .tx_axis_mac_tdata   (m_tdata),
        .tx_axis_mac_tvalid  (m_tvalid),
        .tx_axis_mac_tlast   (m_tlast),
        .tx_axis_mac_tready  (m_tready),
        .tx_axis_rgmii_tdata (r_tdata),
        .tx_axis_rgmii_tvalid(r_tvalid),
        .tx_axis_rgmii_tready(r_tready),
        .tx_underrun         (underrun)
`ifdef TX_FRAME_STATS_EN
        ,
        .tx_frame_cnt        (frame_cnt),
        .tx_underrun_cnt     (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int stall;
        int exp_total;
        int exp_pad;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] out_q[$];
    int         gap_q[$];
    logic [7:0] exp_q[$];
    int         gap_run = 0;
    int         und_pulses = 0;
    int         stall_per = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Test frame content: DA=FF x6, SA=01..06, type 0x0806, payload 0xA5.
    function automatic logic [7:0] pat(input int i);
        if (i < 6)       return 8'hFF;
        else if (i < 12) return 8'(i - 5);
        else if (i == 12) return 8'h08;
        else if (i == 13) return 8'h06;
        else             return 8'hA5;
    endfunction

    // Bit-serial reflected CRC-32 reference.
    function automatic logic [31:0] crc_ref(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Build the expected line stream for a frame of len user bytes.
    task automatic build_exp(input int len);
        logic [31:0] c;
        logic [31:0] f;
        int          n;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        n = 0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pat(i));
            c = crc_ref(c, pat(i));
            n++;
        end
        while (n < 60) begin
            exp_q.push_back(8'h00);
            c = crc_ref(c, 8'h00);
            n++;
        end
        f = ~c;
        exp_q.push_back(f[7:0]);
        exp_q.push_back(f[15:8]);
        exp_q.push_back(f[23:16]);
        exp_q.push_back(f[31:24]);
    endtask

    // RGMII tready cadence: every cycle, or one cycle in stall_per.
    initial begin
        int cyc;
        cyc = 0;
        r_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            r_tready = (stall_per <= 1) ? 1'b1 : ((cyc % stall_per) == 0);
        end
    end

    // Line monitor: captures bytes, gap slots, underrun pulses, stall hold.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!(r_tvalid && (r_tdata == prev_data))) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%0b data=0x%0h expected valid=1 data=0x%0h",
                                 r_tvalid, r_tdata, prev_data);
                    end
                end
                if (r_tvalid && r_tready) begin
                    out_q.push_back(r_tdata);
                    gap_q.push_back(gap_run);
                    gap_run = 0;
                end else if (!r_tvalid && r_tready) begin
                    gap_run++;
                end
                if (underrun) und_pulses++;
                prev_stall = r_tvalid && !r_tready;
                prev_data  = r_tdata;
            end
        end
    end

    // Present one user frame; stop_at >= 0 inserts a starvation gap there.
    task automatic send_frame(input int len, input int stop_at);
        int t;
        int acc;
        acc = 0;
        for (int i = 0; i < len; i++) begin
            if (i == stop_at) begin
                m_tvalid = 1'b0;
                repeat (6) @(posedge clk);
                #1;
            end
            m_tdata  = pat(i);
            m_tlast  = (i == len - 1);
            m_tvalid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!m_tready && t < 3000);
            if (!m_tready) break;
            @(posedge clk);
            #1;
            acc++;
        end
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        chk("user_bytes_accepted", acc, len);
    endtask

    task automatic wait_bytes(input int n);
        int t;
        t = 0;
        while (out_q.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (200) @(negedge clk);
    endtask

    task automatic clear_capture();
        out_q.delete();
        gap_q.delete();
        gap_run = 0;
    endtask

    // Compare one captured frame starting at offset base against the model.
    task automatic check_frame(input string tag, input int base, input int len,
                               input int exp_pad);
        int          nmis;
        int          npre;
        int          nz;
        logic [31:0] res;
        build_exp(len);
        nmis = 0;
        npre = 0;
        nz   = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= out_q.size() || out_q[base + i] !== exp_q[i]) nmis++;
        end
        for (int i = 0; i < 8 && base + i < out_q.size(); i++) begin
            if (out_q[base + i] == ((i < 7) ? 8'h55 : 8'hD5)) npre++;
        end
        for (int i = 8 + len; i < 8 + len + exp_pad && base + i < out_q.size(); i++) begin
            if (out_q[base + i] == 8'h00) nz++;
        end
        res = 32'hFFFFFFFF;
        for (int i = 8; i < exp_q.size() && base + i < out_q.size(); i++) begin
            res = crc_ref(res, out_q[base + i]);
        end
        chk({tag, "_byte_mismatches"}, nmis, 0);
        chk({tag, "_preamble_sfd"}, npre, 8);
        chk({tag, "_pad_zeros"}, nz, exp_pad);
        chk({tag, "_crc_residue"}, res, 32'hDEBB20E3);
    endtask

    initial begin
        vec_t vecs[5];
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{len: 60, stall: 1,  exp_total: 72, exp_pad: 0};
        vecs[1] = '{len: 14, stall: 1,  exp_total: 72, exp_pad: 46};
        vecs[2] = '{len: 60, stall: 10, exp_total: 72, exp_pad: 0};
        vecs[3] = '{len: 64, stall: 1,  exp_total: 76, exp_pad: 0};
        vecs[4] = '{len: 1,  stall: 3,  exp_total: 72, exp_pad: 59};

        rst      = 1'b1;
        m_tdata  = 8'h00;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tvalid", r_tvalid, 0);
        chk("reset_tdata", r_tdata, 8'h00);
        chk("reset_mac_tready", m_tready, 0);
        chk("reset_underrun", underrun, 0);
`ifdef TX_FRAME_STATS_EN
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_underrun_cnt", underrun_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven single frames.
        for (int v = 0; v < 5; v++) begin
            clear_capture();
            stall_per = vecs[v].stall;
            send_frame(vecs[v].len, -1);
            wait_bytes(vecs[v].exp_total);
            chk($sformatf("vec%0d_total_bytes", v), out_q.size(), vecs[v].exp_total);
            check_frame($sformatf("vec%0d", v), 0, vecs[v].len, vecs[v].exp_pad);
            stall_per = 1;
        end

        // Back-to-back frames: exactly 12 idle byte slots between them.
        clear_capture();
        send_frame(60, -1);
        send_frame(60, -1);
        wait_bytes(144);
        chk("b2b_total_bytes", out_q.size(), 144);
        chk("b2b_ifg_slots", (gap_q.size() > 72) ? gap_q[72] : -1, 12);
        check_frame("b2b_first", 0, 60, 0);
        check_frame("b2b_second", 72, 60, 0);

        // Underrun after 20 data bytes, then drain through tlast.
        clear_capture();
        und_pulses = 0;
        send_frame(40, 20);
        repeat (100) @(negedge clk);
        chk("underrun_pulses", und_pulses, 1);
        chk("underrun_truncated_len", out_q.size(), 28);
        chk("underrun_mac_tready_after_drain", m_tready, 0);
        clear_capture();
        send_frame(60, -1);
        wait_bytes(72);
        chk("post_underrun_total", out_q.size(), 72);
        check_frame("post_underrun", 0, 60, 0);
`ifdef TX_FRAME_STATS_EN
        chk("stats_underrun_cnt", underrun_cnt, 1);
        chk("stats_frame_cnt", frame_cnt, 8);
`endif

        // Reset pulse while padding a short frame.
        clear_capture();
        send_frame(14, -1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("pad_reset_tvalid", r_tvalid, 0);
        chk("pad_reset_tdata", r_tdata, 8'h00);
        chk("pad_reset_mac_tready", m_tready, 0);
`ifdef TX_FRAME_STATS_EN
        chk("pad_reset_frame_cnt", frame_cnt, 0);
`endif
        repeat (5) @(negedge clk);
        chk("pad_reset_no_output", r_tvalid, 0);
        clear_capture();
        send_frame(60, -1);
        wait_bytes(72);
        chk("after_reset_total", out_q.size(), 72);
        check_frame("after_reset", 0, 60, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
